// File: rtl/micro_datapath.sv
// Register-transfer CPU datapath: register file, Y/HI/LO/Z/PC/MAR/MDR, single bus, ALU.
// One micro-command per handshake; memory accesses use req/ack with a bounded wait.
module micro_datapath #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned NUM_REGS    = 16,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                        clk,
  input  logic                        clr,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [2:0]                  cmd_src,
  input  logic [$clog2(NUM_REGS)-1:0] cmd_src_reg,
  input  logic                        cmd_ba,
  input  logic [DATA_W-1:0]           cmd_imm,
  input  logic [NUM_REGS-1:0]         cmd_dst_regs,
  input  logic [5:0]                  cmd_dst_misc,
  input  logic                        cmd_z_en,
  input  logic [3:0]                  cmd_alu_op,
  input  logic                        cmd_pc_inc,
  input  logic [1:0]                  cmd_mem,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  input  logic                        mem_ack,
  output logic [DATA_W-1:0]           bus_dbg,
  output logic [DATA_W-1:0]           zlo_data,
  output logic                        err
);

  localparam int unsigned ShW  = $clog2(DATA_W);
  localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [0:0] {StIdle, StMem} state_e;

  state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            we_q, we_d;
  logic            err_q, err_d;
  logic            mdr_from_mem;

  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] y_q, hi_q, lo_q, zhi_q, zlo_q, pc_q, mdr_q;
  // Only the addressable bits of MAR are ever observed, so only those are stored.
  logic [ADDR_W-1:0] mar_q;

  logic              accept;
  logic [DATA_W-1:0] bus;
  logic [DATA_W-1:0] alu_hi, alu_lo;
  logic [ShW-1:0]    shamt;
  logic [2*DATA_W-1:0] prod;

  assign cmd_ready = (state_q == StIdle);
  assign accept    = cmd_valid && cmd_ready;

  always_comb begin
    bus = '0;
    case (cmd_src)
      3'd0:    bus = (cmd_ba && cmd_src_reg == '0) ? '0 : regs_q[cmd_src_reg];
      3'd1:    bus = hi_q;
      3'd2:    bus = lo_q;
      3'd3:    bus = zhi_q;
      3'd4:    bus = zlo_q;
      3'd5:    bus = pc_q;
      3'd6:    bus = mdr_q;
      default: bus = cmd_imm;
    endcase
  end

  assign shamt = bus[ShW-1:0];
  assign prod  = $signed({{DATA_W{y_q[DATA_W-1]}}, y_q}) *
                 $signed({{DATA_W{bus[DATA_W-1]}}, bus});

  always_comb begin
    alu_hi = '0;
    alu_lo = bus;
    case (cmd_alu_op)
      4'd0:    alu_lo = y_q + bus;
      4'd1:    alu_lo = y_q - bus;
      4'd2:    alu_lo = y_q & bus;
      4'd3:    alu_lo = y_q | bus;
      4'd4:    alu_lo = y_q << shamt;
      4'd5:    alu_lo = y_q >> shamt;
      4'd6:    alu_lo = $unsigned($signed(y_q) >>> shamt);
      4'd7:    {alu_hi, alu_lo} = prod;
      4'd8:    alu_lo = '0 - bus;
      4'd9:    alu_lo = ~bus;
      default: alu_lo = bus;
    endcase
  end

  // Memory handshake: wait at most MEM_TIMEOUT cycles in StMem, ack wins on the last one.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    err_d        = err_q;
    mdr_from_mem = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept && (cmd_mem == 2'd1 || cmd_mem == 2'd2)) begin
          state_d = StMem;
          cnt_d   = '0;
          we_d    = (cmd_mem == 2'd2);
        end
      end
      StMem: begin
        if (mem_ack) begin
          state_d      = StIdle;
          mdr_from_mem = !we_q;
        end else if (cnt_q == CntW'(MEM_TIMEOUT - 1)) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (accept) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        if (cmd_dst_regs[i]) regs_q[i] <= bus;
      end
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      y_q   <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
      zhi_q <= '0;
      zlo_q <= '0;
      pc_q  <= '0;
      mar_q <= '0;
      mdr_q <= '0;
    end else begin
      if (accept) begin
        if (cmd_dst_misc[0]) y_q   <= bus;
        if (cmd_dst_misc[1]) hi_q  <= bus;
        if (cmd_dst_misc[2]) lo_q  <= bus;
        if (cmd_dst_misc[4]) mar_q <= bus[ADDR_W-1:0];
        if (cmd_dst_misc[5]) mdr_q <= bus;
        if (cmd_dst_misc[3]) begin
          pc_q <= bus;
        end else if (cmd_pc_inc) begin
          pc_q <= pc_q + DATA_W'(1);
        end
        if (cmd_z_en) begin
          zhi_q <= alu_hi;
          zlo_q <= alu_lo;
        end
      end
      // Accept happens only in StIdle, so this never collides with the bus load above.
      if (mdr_from_mem) mdr_q <= mem_rdata;
    end
  end

  assign mem_req   = (state_q == StMem);
  assign mem_we    = mem_req && we_q;
  assign mem_addr  = mar_q;
  assign mem_wdata = mdr_q;
  assign bus_dbg   = bus;
  assign zlo_data  = zlo_q;
  assign err       = err_q;

endmodule

// File: tb/tb_micro_datapath.sv
// Randomized self-checking bench for micro_datapath against a behavioural model.
module tb_micro_datapath;

  localparam int TO = 15;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_src = '0;
  logic [3:0]  cmd_src_reg = '0;
  logic        cmd_ba = 1'b0;
  logic [31:0] cmd_imm = '0;
  logic [15:0] cmd_dst_regs = '0;
  logic [5:0]  cmd_dst_misc = '0;
  logic        cmd_z_en = 1'b0;
  logic [3:0]  cmd_alu_op = '0;
  logic        cmd_pc_inc = 1'b0;
  logic [1:0]  cmd_mem = '0;
  logic        mem_req, mem_we;
  logic [8:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] bus_dbg, zlo_data;
  logic        err;

  micro_datapath #(
    .DATA_W(32), .NUM_REGS(16), .ADDR_W(9), .MEM_TIMEOUT(TO)
  ) dut (
    .clk(clk), .clr(clr), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_src(cmd_src), .cmd_src_reg(cmd_src_reg), .cmd_ba(cmd_ba), .cmd_imm(cmd_imm),
    .cmd_dst_regs(cmd_dst_regs), .cmd_dst_misc(cmd_dst_misc), .cmd_z_en(cmd_z_en),
    .cmd_alu_op(cmd_alu_op), .cmd_pc_inc(cmd_pc_inc), .cmd_mem(cmd_mem),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .bus_dbg(bus_dbg), .zlo_data(zlo_data),
    .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference state
  logic [31:0] m_r [16];
  logic [31:0] m_y, m_hi, m_lo, m_zhi, m_zlo, m_pc, m_mar, m_mdr;
  logic        m_err;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_r[i] = '0;
    m_y = '0; m_hi = '0; m_lo = '0; m_zhi = '0; m_zlo = '0;
    m_pc = '0; m_mar = '0; m_mdr = '0; m_err = 1'b0;
  endtask

  function automatic logic [31:0] model_bus();
    case (cmd_src)
      3'd0:    return (cmd_ba && cmd_src_reg == 4'd0) ? 32'd0 : m_r[cmd_src_reg];
      3'd1:    return m_hi;
      3'd2:    return m_lo;
      3'd3:    return m_zhi;
      3'd4:    return m_zlo;
      3'd5:    return m_pc;
      3'd6:    return m_mdr;
      default: return cmd_imm;
    endcase
  endfunction

  function automatic logic [63:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    int unsigned sh;
    int sa, sb;
    longint p;
    logic [31:0] r;
    sh = b % 32;
    sa = a;
    sb = b;
    case (op)
      4'd0: r = a + b;
      4'd1: r = a - b;
      4'd2: r = a & b;
      4'd3: r = a | b;
      4'd4: r = a << sh;
      4'd5: r = a >> sh;
      4'd6: begin sa = sa >>> sh; r = sa; end
      4'd7: begin p = longint'(sa) * longint'(sb); return p; end
      4'd8: r = 32'd0 - b;
      4'd9: r = ~b;
      default: r = b;
    endcase
    return {32'd0, r};
  endfunction

  // Runs the memory phase; entered at posedge+1 after the accept edge.
  task automatic mem_phase(input int ack_at, input logic [31:0] rd, input bit is_wr,
                           output int reqcnt, output int ready_low);
    int exp_cnt;
    reqcnt = 0;
    ready_low = 0;
    for (int k = 1; k <= TO + 5; k++) begin
      if (!mem_req) break;
      if (k == 1) begin
        check("mem_addr", mem_addr, m_mar[8:0]);
        check("mem_we", mem_we, is_wr);
        check("mem_wdata", mem_wdata, m_mdr);
      end
      if (!cmd_ready) ready_low++;
      mem_ack = (k == ack_at);
      mem_rdata = rd;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      reqcnt++;
    end
    exp_cnt = (ack_at >= 1 && ack_at <= TO) ? ack_at : TO;
    check("req_cycles", reqcnt, exp_cnt);
    if (ack_at >= 1 && ack_at <= TO) begin
      if (!is_wr) m_mdr = rd;
    end else begin
      m_err = 1'b1;
    end
    check("err", err, m_err);
    check("ready_after_mem", cmd_ready, 1'b1);
  endtask

  // Issues the command currently on the cmd_* inputs; entry and exit at posedge+1.
  // ack_at < 0 leaves a memory command parked in its memory phase.
  task automatic send(input int ack_at, input logic [31:0] rd);
    logic [31:0] b;
    logic [63:0] res;
    int rc, rl;
    cmd_valid = 1'b1;
    #2;
    check("ready", cmd_ready, 1'b1);
    b = model_bus();
    check("bus", bus_dbg, b);
    res = ref_alu(cmd_alu_op, m_y, b);
    @(posedge clk);
    for (int i = 0; i < 16; i++) if (cmd_dst_regs[i]) m_r[i] = b;
    if (cmd_dst_misc[0]) m_y = b;
    if (cmd_dst_misc[1]) m_hi = b;
    if (cmd_dst_misc[2]) m_lo = b;
    if (cmd_dst_misc[4]) m_mar = b;
    if (cmd_dst_misc[5]) m_mdr = b;
    if (cmd_dst_misc[3]) m_pc = b;
    else if (cmd_pc_inc) m_pc = m_pc + 1;
    if (cmd_z_en) begin m_zhi = res[63:32]; m_zlo = res[31:0]; end
    #1;
    cmd_valid = 1'b0;
    if ((cmd_mem == 2'd1 || cmd_mem == 2'd2) && ack_at >= 0) begin
      mem_phase(ack_at, rd, cmd_mem == 2'd2, rc, rl);
    end
    check("zlo", zlo_data, m_zlo);
    check("mem_addr_post", mem_addr, m_mar[8:0]);
    check("mdr_out", mem_wdata, m_mdr);
  endtask

  task automatic set_cmd(input logic [2:0] src, input logic [3:0] sreg, input logic [31:0] imm,
                         input logic [15:0] dregs, input logic [5:0] dmisc, input logic z,
                         input logic [3:0] op, input logic inc, input logic [1:0] mem);
    cmd_src = src; cmd_src_reg = sreg; cmd_ba = 1'b0; cmd_imm = imm; cmd_dst_regs = dregs;
    cmd_dst_misc = dmisc; cmd_z_en = z; cmd_alu_op = op; cmd_pc_inc = inc; cmd_mem = mem;
  endtask

  task automatic peek(input logic [2:0] src, input logic [3:0] sreg, input logic [31:0] exp,
                      input string tag);
    cmd_valid = 1'b0; cmd_src = src; cmd_src_reg = sreg; cmd_ba = 1'b0;
    #2;
    check(tag, bus_dbg, exp);
    @(posedge clk); #1;
  endtask

  task automatic peek_all();
    for (int i = 0; i < 16; i++) peek(3'd0, 4'(i), m_r[i], "peek_reg");
    peek(3'd1, 4'd0, m_hi, "peek_hi");
    peek(3'd2, 4'd0, m_lo, "peek_lo");
    peek(3'd3, 4'd0, m_zhi, "peek_zhi");
    peek(3'd4, 4'd0, m_zlo, "peek_zlo");
    peek(3'd5, 4'd0, m_pc, "peek_pc");
    peek(3'd6, 4'd0, m_mdr, "peek_mdr");
  endtask

  initial begin
    int rc, rl;
    model_reset();
    #12;
    check("rst_ready", cmd_ready, 1'b1);
    check("rst_req", mem_req, 1'b0);
    check("rst_we", mem_we, 1'b0);
    check("rst_err", err, 1'b0);
    check("rst_bus", bus_dbg, 32'd0);
    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1;

    // Load 5 into r3 and Y, then Y + r3
    set_cmd(3'd7, 4'd0, 32'd5, 16'h0008, 6'b000001, 1'b0, 4'd0, 1'b0, 2'd0);
    send(0, 0);
    set_cmd(3'd0, 4'd3, 32'd0, 16'h0000, 6'b000000, 1'b1, 4'd0, 1'b0, 2'd0);
    send(0, 0);
    check("add_zlo", zlo_data, 32'd10);
    peek(3'd3, 4'd0, 32'd0, "add_zhi");
    // r0 nonzero, then bus-zero via cmd_ba
    set_cmd(3'd7, 4'd0, 32'h77, 16'h0001, 6'b0, 1'b0, 4'd0, 1'b0, 2'd0);
    send(0, 0);
    cmd_src = 3'd0; cmd_src_reg = 4'd0; cmd_ba = 1'b1; cmd_valid = 1'b0;
    #2; check("ba_bus", bus_dbg, 32'd0);
    @(posedge clk); #1;

    // Signed multiply -1 * 2
    set_cmd(3'd7, 4'd0, 32'hFFFF_FFFF, 16'h0, 6'b000001, 1'b0, 4'd0, 1'b0, 2'd0);
    send(0, 0);
    set_cmd(3'd7, 4'd0, 32'd2, 16'h0, 6'b0, 1'b1, 4'd7, 1'b0, 2'd0);
    send(0, 0);
    check("mul_zlo", zlo_data, 32'hFFFF_FFFE);
    peek(3'd3, 4'd0, 32'hFFFF_FFFF, "mul_zhi");
    // Arithmetic shift right
    set_cmd(3'd7, 4'd0, 32'h8000_0000, 16'h0, 6'b000001, 1'b0, 4'd0, 1'b0, 2'd0);
    send(0, 0);
    set_cmd(3'd7, 4'd0, 32'd4, 16'h0, 6'b0, 1'b1, 4'd6, 1'b0, 2'd0);
    send(0, 0);
    check("shra_zlo", zlo_data, 32'hF800_0000);

    // Write with ack in 4th memory cycle, then single-cycle read
    set_cmd(3'd7, 4'd0, 32'h1F0, 16'h0, 6'b110000, 1'b0, 4'd0, 1'b0, 2'd0);
    send(0, 0);
    set_cmd(3'd0, 4'd1, 32'd0, 16'h0, 6'b0, 1'b0, 4'd0, 1'b0, 2'd2);
    send(-1, 0);
    check("wr_addr", mem_addr, 9'h1F0);
    check("wr_data", mem_wdata, 32'h1F0);
    check("wr_we", mem_we, 1'b1);
    mem_phase(4, 0, 1'b1, rc, rl);
    check("wr_ready_low", rl, 4);
    set_cmd(3'd0, 4'd1, 32'd0, 16'h0, 6'b0, 1'b0, 4'd0, 1'b0, 2'd1);
    send(1, 32'hDEAD_BEEF);
    peek(3'd6, 4'd0, 32'hDEAD_BEEF, "rd_mdr");

    // Read timeout, late ack ignored, next command normal
    set_cmd(3'd0, 4'd1, 32'd0, 16'h0, 6'b0, 1'b0, 4'd0, 1'b0, 2'd1);
    send(0, 32'h1234_5678);
    check("to_err", err, 1'b1);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("late_ack_req", mem_req, 1'b0);
    check("err_sticky", err, 1'b1);
    peek(3'd6, 4'd0, 32'hDEAD_BEEF, "to_mdr");
    set_cmd(3'd7, 4'd0, 32'hABCD, 16'h0002, 6'b0, 1'b0, 4'd0, 1'b0, 2'd0);
    send(0, 0);
    peek(3'd0, 4'd1, 32'hABCD, "after_to");

    // PC increment / load precedence / wrap
    set_cmd(3'd7, 4'd0, 32'd7, 16'h0, 6'b001000, 1'b0, 4'd0, 1'b0, 2'd0);
    send(0, 0);
    set_cmd(3'd0, 4'd0, 32'd0, 16'h0, 6'b0, 1'b0, 4'd0, 1'b1, 2'd0);
    send(0, 0);
    peek(3'd5, 4'd0, 32'd8, "pc_inc");
    set_cmd(3'd7, 4'd0, 32'h40, 16'h0, 6'b001000, 1'b0, 4'd0, 1'b1, 2'd0);
    send(0, 0);
    peek(3'd5, 4'd0, 32'h40, "pc_load_wins");
    set_cmd(3'd7, 4'd0, 32'hFFFF_FFFF, 16'h0, 6'b001000, 1'b0, 4'd0, 1'b0, 2'd0);
    send(0, 0);
    set_cmd(3'd0, 4'd0, 32'd0, 16'h0, 6'b0, 1'b0, 4'd0, 1'b1, 2'd0);
    send(0, 0);
    peek(3'd5, 4'd0, 32'd0, "pc_wrap");

    // Random traffic, mostly back-to-back
    for (int n = 0; n < 300; n++) begin
      set_cmd(3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), $urandom,
              16'($urandom & $urandom & $urandom), 6'($urandom & $urandom),
              1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              1'($urandom_range(0, 1)), 2'd0);
      cmd_ba = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 9) < 2) cmd_mem = 2'($urandom_range(1, 2));
      else if ($urandom_range(0, 9) == 0) cmd_mem = 2'd3;
      send($urandom_range(0, TO + 2), $urandom);
      if (n % 50 == 49) peek_all();
    end
    peek_all();

    // Async reset while a request is outstanding
    set_cmd(3'd0, 4'd0, 32'd0, 16'h0, 6'b0, 1'b0, 4'd0, 1'b0, 2'd1);
    send(-1, 0);
    check("pre_rst_req", mem_req, 1'b1);
    cmd_src = 3'd0; cmd_src_reg = 4'd0; cmd_ba = 1'b0;
    #2; clr = 1'b0; #1;
    model_reset();
    check("mid_rst_req", mem_req, 1'b0);
    check("mid_rst_ready", cmd_ready, 1'b1);
    check("mid_rst_err", err, 1'b0);
    check("mid_rst_zlo", zlo_data, 32'd0);
    check("mid_rst_bus", bus_dbg, 32'd0);
    @(negedge clk); clr = 1'b1;
    @(posedge clk); #1;
    peek_all();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
